// File: rtl/gram_pkg.sv
// Shared types and default constants for the frame-buffer SDRAM scheduler.
package gram_pkg;

    localparam int BANK_W_D        = 2;
    localparam int ROWCOL_W_D      = 22;
    localparam int FIFO_AW_D       = 9;
    localparam int BLK_LEN_D       = 256;
    localparam int BLK_PER_FRAME_D = 1200;
    localparam int RD_URGENT_D     = 64;
    localparam int TIMEOUT_D       = 1023;
    // Wide enough for up to 8192 bursts per frame
    localparam int BLK_CNT_W       = 13;

    typedef enum logic {
        GR_WR = 1'b0,
        GR_RD = 1'b1
    } grant_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_WR  = 3'd1,
        ST_WAIT_WR = 3'd2,
        ST_REQ_RD  = 3'd3,
        ST_WAIT_RD = 3'd4
    } state_t;

endpackage

// File: rtl/gram_addr_gen.sv
// Burst address generator: block counter, rowcol offset and frame bank.
// CMP_SWAP=1 only flips the bank at frame end when it collides with the other side.
module gram_addr_gen
    import gram_pkg::*;
#(
    parameter int                    BANK_WIDTH    = BANK_W_D,
    parameter int                    ROWCOL_WIDTH  = ROWCOL_W_D,
    parameter int                    BLK_LEN       = BLK_LEN_D,
    parameter int                    BLK_PER_FRAME = BLK_PER_FRAME_D,
    parameter logic [BANK_WIDTH-1:0] RST_BANK      = '0,
    parameter bit                    CMP_SWAP      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_advance,
    input  logic [BANK_WIDTH-1:0]   i_other_bank,
    output logic [BANK_WIDTH-1:0]   o_bank,
    output logic [ROWCOL_WIDTH-1:0] o_rowcol,
    output logic                    o_frame_done
);

    logic [BLK_CNT_W-1:0]    r_blk_cnt;
    logic [BANK_WIDTH-1:0]   r_bank;
    logic [ROWCOL_WIDTH-1:0] r_rowcol;
    logic                    r_frame_done;
    logic                    w_last_blk;
    logic                    w_swap;

    assign w_last_blk = (r_blk_cnt == BLK_CNT_W'(BLK_PER_FRAME - 1));
    // Reader keeps re-reading a frame until the writer has moved onto its bank
    assign w_swap     = !CMP_SWAP || (r_bank == i_other_bank);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt    <= '0;
            r_bank       <= RST_BANK;
            r_rowcol     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (i_advance) begin
                if (w_last_blk) begin
                    r_blk_cnt    <= '0;
                    r_rowcol     <= '0;
                    r_frame_done <= 1'b1;
                    if (w_swap) begin
                        r_bank <= ~r_bank;
                    end
                end else begin
                    r_blk_cnt <= r_blk_cnt + BLK_CNT_W'(1);
                    r_rowcol  <= r_rowcol + ROWCOL_WIDTH'(BLK_LEN);
                end
            end
        end
    end

    assign o_bank       = r_bank;
    assign o_rowcol     = r_rowcol;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/gram_sched.sv
// Single-outstanding-burst scheduler between the camera/VGA FIFOs and the SDRAM core,
// with read-urgency priority, round-robin fairness and a completion watchdog.
module gram_sched
    import gram_pkg::*;
#(
    parameter int BANK_WIDTH    = BANK_W_D,
    parameter int ROWCOL_WIDTH  = ROWCOL_W_D,
    parameter int FIFO_AW       = FIFO_AW_D,
    parameter int BLK_LEN       = BLK_LEN_D,
    parameter int BLK_PER_FRAME = BLK_PER_FRAME_D,
    parameter int RD_URGENT     = RD_URGENT_D,
    parameter int TIMEOUT       = TIMEOUT_D
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               init_done,
    input  logic [FIFO_AW-1:0]                 wr_fifo_level,
    input  logic [FIFO_AW-1:0]                 rd_fifo_level,
    input  logic                               wr_busy,
    input  logic                               rd_busy,
    output logic                               wr_request,
    output logic [BANK_WIDTH+ROWCOL_WIDTH-1:0] wr_addr,
    output logic                               rd_request,
    output logic [BANK_WIDTH+ROWCOL_WIDTH-1:0] rd_addr,
    output logic                               wr_frame_done,
    output logic                               rd_frame_done,
    output logic                               timeout_err
);

    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int WD_W       = $clog2(TIMEOUT + 1);

    state_t                  r_state;
    state_t                  w_state_next;
    grant_t                  r_last_grant;
    logic                    r_seen_busy;
    logic [WD_W-1:0]         r_wdog;
    logic                    r_timeout_err;

    logic                    w_wr_elig;
    logic                    w_rd_elig;
    logic                    w_rd_urgent;
    logic                    w_wait_busy;
    logic                    w_wdog_hit;
    logic                    w_wr_adv;
    logic                    w_rd_adv;
    logic                    w_expire;
    logic [BANK_WIDTH-1:0]   w_wr_bank;
    logic [BANK_WIDTH-1:0]   w_rd_bank;
    logic [ROWCOL_WIDTH-1:0] w_wr_rowcol;
    logic [ROWCOL_WIDTH-1:0] w_rd_rowcol;

    assign w_wr_elig   = init_done && (int'(wr_fifo_level) >= BLK_LEN) && !wr_busy && !rd_busy;
    assign w_rd_elig   = init_done && (int'(rd_fifo_level) <= (FIFO_DEPTH - BLK_LEN))
                         && !wr_busy && !rd_busy;
    assign w_rd_urgent = (int'(rd_fifo_level) < RD_URGENT);
    assign w_wait_busy = (r_state == ST_WAIT_WR) ? wr_busy : rd_busy;
    assign w_wdog_hit  = (r_wdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        w_wr_adv     = 1'b0;
        w_rd_adv     = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_elig && w_rd_urgent) begin
                    w_state_next = ST_REQ_RD;
                end else if (w_wr_elig && w_rd_elig) begin
                    w_state_next = (r_last_grant == GR_RD) ? ST_REQ_WR : ST_REQ_RD;
                end else if (w_wr_elig) begin
                    w_state_next = ST_REQ_WR;
                end else if (w_rd_elig) begin
                    w_state_next = ST_REQ_RD;
                end
            end
            ST_REQ_WR: w_state_next = ST_WAIT_WR;
            ST_REQ_RD: w_state_next = ST_WAIT_RD;
            ST_WAIT_WR: begin
                // A genuine completion wins over a watchdog hit in the same cycle
                if (r_seen_busy && !wr_busy) begin
                    w_state_next = ST_IDLE;
                    w_wr_adv     = 1'b1;
                end else if (w_wdog_hit) begin
                    w_state_next = ST_IDLE;
                    w_expire     = 1'b1;
                end
            end
            ST_WAIT_RD: begin
                if (r_seen_busy && !rd_busy) begin
                    w_state_next = ST_IDLE;
                    w_rd_adv     = 1'b1;
                end else if (w_wdog_hit) begin
                    w_state_next = ST_IDLE;
                    w_expire     = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= GR_RD;
            r_seen_busy   <= 1'b0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timeout_err <= w_expire;
            case (r_state)
                ST_REQ_WR, ST_REQ_RD: begin
                    r_last_grant <= (r_state == ST_REQ_WR) ? GR_WR : GR_RD;
                    r_seen_busy  <= 1'b0;
                    r_wdog       <= '0;
                end
                ST_WAIT_WR, ST_WAIT_RD: begin
                    r_seen_busy <= r_seen_busy | w_wait_busy;
                    r_wdog      <= r_wdog + WD_W'(1);
                end
                default: ;
            endcase
        end
    end

    gram_addr_gen #(
        .BANK_WIDTH    (BANK_WIDTH),
        .ROWCOL_WIDTH  (ROWCOL_WIDTH),
        .BLK_LEN       (BLK_LEN),
        .BLK_PER_FRAME (BLK_PER_FRAME),
        .RST_BANK      ({BANK_WIDTH{1'b0}}),
        .CMP_SWAP      (1'b0)
    ) u_wr_addr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_advance    (w_wr_adv),
        .i_other_bank (w_rd_bank),
        .o_bank       (w_wr_bank),
        .o_rowcol     (w_wr_rowcol),
        .o_frame_done (wr_frame_done)
    );

    gram_addr_gen #(
        .BANK_WIDTH    (BANK_WIDTH),
        .ROWCOL_WIDTH  (ROWCOL_WIDTH),
        .BLK_LEN       (BLK_LEN),
        .BLK_PER_FRAME (BLK_PER_FRAME),
        .RST_BANK      ({BANK_WIDTH{1'b1}}),
        .CMP_SWAP      (1'b1)
    ) u_rd_addr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_advance    (w_rd_adv),
        .i_other_bank (w_wr_bank),
        .o_bank       (w_rd_bank),
        .o_rowcol     (w_rd_rowcol),
        .o_frame_done (rd_frame_done)
    );

    assign wr_request  = (r_state == ST_REQ_WR);
    assign rd_request  = (r_state == ST_REQ_RD);
    assign wr_addr     = {w_wr_bank, w_wr_rowcol};
    assign rd_addr     = {w_rd_bank, w_rd_rowcol};
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_gram_sched.sv
// Directed bench for gram_sched: arbitration vector table, frame/bank rollover,
// watchdog expiry and mid-operation reset.
module tb_gram_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic [8:0]  wr_lvl;
    logic [8:0]  rd_lvl;
    logic        wr_busy;
    logic        rd_busy;
    logic        wr_request;
    logic [23:0] wr_addr;
    logic        rd_request;
    logic [23:0] rd_addr;
    logic        wr_frame_done;
    logic        rd_frame_done;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int wr_fd_cnt = 0;
    int rd_fd_cnt = 0;

    always #5 clk = ~clk;

    gram_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .wr_fifo_level (wr_lvl),
        .rd_fifo_level (rd_lvl),
        .wr_busy       (wr_busy),
        .rd_busy       (rd_busy),
        .wr_request    (wr_request),
        .wr_addr       (wr_addr),
        .rd_request    (rd_request),
        .rd_addr       (rd_addr),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done),
        .timeout_err   (timeout_err)
    );

    always @(negedge clk) begin
        if (wr_frame_done) wr_fd_cnt++;
        if (rd_frame_done) rd_fd_cnt++;
    end

    typedef struct {
        logic [8:0]  wl;
        logic [8:0]  rl;
        bit          exp_req;
        bit          exp_wr;
        logic [23:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_req(input int maxc, output bit got, output bit is_wr, output logic [23:0] a);
        got = 1'b0; is_wr = 1'b0; a = '0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (wr_request || rd_request) begin
                got = 1'b1;
                is_wr = wr_request;
                a = wr_request ? wr_addr : rd_addr;
                break;
            end
        end
    endtask

    // Busy high for blen cycles, then drop busy and park levels at ineligible values
    task automatic ack(input bit is_wr, input int blen, input logic [23:0] a);
        for (int i = 0; i < blen; i++) begin
            @(negedge clk);
            if (i == 0) chk("req_one_cycle", {30'b0, wr_request, rd_request}, 32'd0);
            if (is_wr) wr_busy = 1'b1; else rd_busy = 1'b1;
        end
        @(negedge clk);
        chk("addr_stable", is_wr ? wr_addr : rd_addr, a);
        wr_busy = 1'b0; rd_busy = 1'b0;
        wr_lvl = 9'd0; rd_lvl = 9'd511;
        @(negedge clk);
    endtask

    task automatic do_burst(input string name, input logic [8:0] wl, input logic [8:0] rl,
                            input bit exp_wr, input logic [23:0] exp_addr, input int blen);
        bit got, is_wr;
        logic [23:0] a;
        wr_lvl = wl; rd_lvl = rl;
        wait_req(50, got, is_wr, a);
        chk({name, "_got"}, {31'b0, got}, 32'd1);
        if (got) begin
            chk({name, "_dir"}, {31'b0, is_wr}, {31'b0, exp_wr});
            chk({name, "_addr"}, a, exp_addr);
            $display("burst %s dir=%s addr=%h", name, is_wr ? "W" : "R", a);
            ack(is_wr, blen, a);
        end
    endtask

    initial begin
        int nreq;
        int fd0;
        int c;
        bit got, is_wr;
        logic [23:0] a;

        // wr_lvl, rd_lvl, expect request, expect write, expected address
        vecs[0]  = '{9'd300, 9'd100, 1'b1, 1'b1, 24'h000000};
        vecs[1]  = '{9'd300, 9'd100, 1'b1, 1'b0, 24'hC00000};
        vecs[2]  = '{9'd300, 9'd100, 1'b1, 1'b1, 24'h000100};
        vecs[3]  = '{9'd300, 9'd100, 1'b1, 1'b0, 24'hC00100};
        vecs[4]  = '{9'd300, 9'd40,  1'b1, 1'b0, 24'hC00200};
        vecs[5]  = '{9'd300, 9'd300, 1'b1, 1'b1, 24'h000200};
        vecs[6]  = '{9'd100, 9'd100, 1'b1, 1'b0, 24'hC00300};
        vecs[7]  = '{9'd256, 9'd256, 1'b1, 1'b1, 24'h000300};
        vecs[8]  = '{9'd256, 9'd256, 1'b1, 1'b0, 24'hC00400};
        vecs[9]  = '{9'd255, 9'd257, 1'b0, 1'b0, 24'h000000};
        vecs[10] = '{9'd300, 9'd63,  1'b1, 1'b0, 24'hC00500};
        vecs[11] = '{9'd300, 9'd64,  1'b1, 1'b1, 24'h000400};

        rst_n = 1'b0; init_done = 1'b0;
        wr_lvl = 9'd300; rd_lvl = 9'd100;
        wr_busy = 1'b0; rd_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_addr", wr_addr, 24'h000000);
        chk("rst_rd_addr", rd_addr, 24'hC00000);
        chk("rst_pulses", {28'b0, wr_request, rd_request, wr_frame_done, timeout_err}, 32'd0);

        nreq = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_request || rd_request) nreq++;
        end
        chk("no_req_before_init", nreq, 0);
        $display("init_done low 100 cycles: requests=%0d", nreq);

        init_done = 1'b1;
        wr_lvl = 9'd0; rd_lvl = 9'd511;
        @(negedge clk);
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].exp_req) begin
                do_burst($sformatf("vec%0d", v), vecs[v].wl, vecs[v].rl,
                         vecs[v].exp_wr, vecs[v].exp_addr, 10);
            end else begin
                wr_lvl = vecs[v].wl; rd_lvl = vecs[v].rl;
                wait_req(20, got, is_wr, a);
                chk($sformatf("vec%0d_none", v), {31'b0, got}, 32'd0);
                $display("burst vec%0d none got=%0d", v, got);
                wr_lvl = 9'd0; rd_lvl = 9'd511;
                @(negedge clk);
            end
        end

        // Finish the write frame (5 blocks already done), then bank flips to 11
        fd0 = wr_fd_cnt;
        for (int i = 0; i < 1195; i++)
            do_burst("wframe", 9'd300, 9'd511, 1'b1, {2'b00, 22'((5 + i) * 256)}, 1);
        @(posedge clk);
        chk("wr_frame_done_once", wr_fd_cnt - fd0, 1);
        do_burst("wframe_next", 9'd300, 9'd511, 1'b1, 24'hC00000, 1);

        // Read frame ends with rd_bank == wr_bank: 11 -> 00
        fd0 = rd_fd_cnt;
        for (int i = 0; i < 1194; i++)
            do_burst("rframe1", 9'd0, 9'd100, 1'b0, {2'b11, 22'((6 + i) * 256)}, 1);
        @(posedge clk);
        chk("rd_frame_done_swap", rd_fd_cnt - fd0, 1);

        // Read frame ends with rd_bank != wr_bank: bank holds, frame re-read
        fd0 = rd_fd_cnt;
        for (int i = 0; i < 1200; i++)
            do_burst("rframe2", 9'd0, 9'd100, 1'b0, {2'b00, 22'(i * 256)}, 1);
        @(posedge clk);
        chk("rd_frame_done_hold", rd_fd_cnt - fd0, 1);
        do_burst("rframe2_next", 9'd0, 9'd100, 1'b0, 24'h000000, 1);

        // Watchdog: busy never rises
        wr_lvl = 9'd300; rd_lvl = 9'd511;
        wait_req(50, got, is_wr, a);
        chk("to_req_got", {31'b0, got}, 32'd1);
        chk("to_req_addr", a, 24'hC00100);
        c = 0;
        while (c < 2000) begin
            @(negedge clk);
            c++;
            if (timeout_err) break;
        end
        chk("timeout_cycles", c, 1024);
        $display("watchdog: timeout_err after %0d cycles", c);
        @(negedge clk);
        chk("timeout_one_cycle", {31'b0, timeout_err}, 32'd0);
        chk("reissue_req", {31'b0, wr_request}, 32'd1);
        chk("reissue_addr", wr_addr, 24'hC00100);
        ack(1'b1, 10, 24'hC00100);
        chk("after_reissue_addr", wr_addr, 24'hC00200);

        // Reset while a burst is outstanding
        wr_lvl = 9'd300; rd_lvl = 9'd511;
        wait_req(50, got, is_wr, a);
        @(negedge clk);
        wr_busy = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", {30'b0, wr_request, rd_request}, 32'd0);
        chk("midrst_wr_addr", wr_addr, 24'h000000);
        chk("midrst_rd_addr", rd_addr, 24'hC00000);
        $display("mid-op reset: wr_addr=%h rd_addr=%h", wr_addr, rd_addr);
        wr_busy = 1'b0;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
